// File: rtl/fadd_pipe_pkg.sv
// Shared constants and helpers for the pipelined adder/subtractor.
package fadd_pipe_pkg;

   localparam logic ADD = 1'b1;
   localparam logic SUB = 1'b0;

   // Number of pipeline slices: ceiling of width / stage_bits
   function automatic int nst(input int width, input int stage_bits);
      return (width + stage_bits - 1) / stage_bits;
   endfunction

endpackage

// File: rtl/fadd_pipe_addsub_if.sv
// Operand / result bundle of the pipelined adder/subtractor.
// Handshake: an operation is accepted at a rising CK edge where CE=1 and
// VLD_I=1; its result is shown while VLD_O=1 and is consumed by the next
// CE=1 edge. CE=0 freezes the whole pipeline; there is no other backpressure.
interface fadd_pipe_addsub_if #(
   parameter int WIDTH = 16
);
   logic             CE;
   logic             VLD_I;
   logic             ADDSUB;
   logic             CI;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             VLD_O;
   logic [WIDTH-1:0] S;
   logic             COUT;
   logic             OVF;

   modport master (
      output CE, VLD_I, ADDSUB, CI, A, B,
      input  VLD_O, S, COUT, OVF
   );

   modport slave (
      input  CE, VLD_I, ADDSUB, CI, A, B,
      output VLD_O, S, COUT, OVF
   );
endinterface

// File: rtl/fadd_pipe_addsub_slice.sv
// Combinational W-bit ripple adder slice; also exposes the carry into its MSB
// so the top slice can derive signed overflow.
module fadd_slice #(
   parameter int W = 2
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] s,
   output logic         co,
   output logic         c_msb_in
);
   logic c;

   // Bit-serial ripple through the slice, capturing the carry entering the MSB
   always_comb begin
      c        = ci;
      s        = '0;
      c_msb_in = 1'b0;
      for (int i = 0; i < W; i++) begin
         if (i == W - 1) c_msb_in = c;
         s[i] = a[i] ^ b[i] ^ c;
         c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      co = c;
   end
endmodule

// File: rtl/fadd_pipe_addsub.sv
// Pipelined adder/subtractor: operands are skewed per slice, carries between
// slices are registered, and slice sums are deskewed so every bit of one
// operation leaves together, NST cycles after it was accepted.
module fadd_pipe_addsub
   import fadd_pipe_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int STAGE_BITS = 2
) (
   input logic               CK,
   input logic               RSTN,
   fadd_pipe_addsub_if.slave bus
);
   localparam int NST = nst(WIDTH, STAGE_BITS);

   logic [NST-1:0]   vld_d, vld_q;
   logic             ci_d, ci_q;
   logic [NST-1:0]   cy_in;
   logic [WIDTH-1:0] s_out;

   // Valid shift register and registered carry-in advance only on CE
   always_comb begin
      vld_d = vld_q;
      ci_d  = ci_q;
      if (bus.CE) begin
         vld_d[0] = bus.VLD_I;
         ci_d     = bus.CI;
         for (int i = 1; i < NST; i++) vld_d[i] = vld_q[i-1];
      end
   end

   // Valid and carry-in flops, cleared asynchronously
   always_ff @(posedge CK or negedge RSTN) begin
      if (!RSTN) begin
         vld_q <= '0;
         ci_q  <= 1'b0;
      end else begin
         vld_q <= vld_d;
         ci_q  <= ci_d;
      end
   end

   assign cy_in[0]  = ci_q;
   assign bus.VLD_O = vld_q[NST-1];
   assign bus.S     = s_out;

   for (genvar k = 0; k < NST; k++) begin : g_sl
      localparam int LO = k * STAGE_BITS;
      localparam int W  = (WIDTH - LO < STAGE_BITS) ? (WIDTH - LO) : STAGE_BITS;

      logic [W-1:0] a_sk_d [k+1];
      logic [W-1:0] a_sk_q [k+1];
      logic [W-1:0] b_sk_d [k+1];
      logic [W-1:0] b_sk_q [k+1];
      logic [W-1:0] s_sl;
      logic         co;
      logic         c_msb_in;

      // Input skew: B is inverted for subtract as it enters, then both operands
      // are delayed k cycles to meet the carry from the slice below
      always_comb begin
         a_sk_d = a_sk_q;
         b_sk_d = b_sk_q;
         if (bus.CE) begin
            a_sk_d[0] = bus.A[LO +: W];
            b_sk_d[0] = (bus.ADDSUB == ADD) ? bus.B[LO +: W] : ~bus.B[LO +: W];
            for (int j = 1; j <= k; j++) begin
               a_sk_d[j] = a_sk_q[j-1];
               b_sk_d[j] = b_sk_q[j-1];
            end
         end
      end

      // Skew flops, cleared asynchronously
      always_ff @(posedge CK or negedge RSTN) begin
         if (!RSTN) begin
            for (int j = 0; j <= k; j++) begin
               a_sk_q[j] <= '0;
               b_sk_q[j] <= '0;
            end
         end else begin
            a_sk_q <= a_sk_d;
            b_sk_q <= b_sk_d;
         end
      end

      fadd_slice #(.W(W)) u_slice (
         .a        (a_sk_q[k]),
         .b        (b_sk_q[k]),
         .ci       (cy_in[k]),
         .s        (s_sl),
         .co       (co),
         .c_msb_in (c_msb_in)
      );

      if (k == NST - 1) begin : g_last
         assign s_out[LO +: W] = s_sl;
         assign bus.COUT       = co;
         assign bus.OVF        = co ^ c_msb_in;
      end else begin : g_mid
         localparam int D = NST - 1 - k;

         logic         co_d, co_q;
         logic [W-1:0] s_dk_d [D];
         logic [W-1:0] s_dk_q [D];
         logic         unused_c_msb;

         assign unused_c_msb   = c_msb_in;
         assign cy_in[k+1]     = co_q;
         assign s_out[LO +: W] = s_dk_q[D-1];

         // Inter-slice carry register and output deskew chain, both held by CE
         always_comb begin
            co_d   = co_q;
            s_dk_d = s_dk_q;
            if (bus.CE) begin
               co_d      = co;
               s_dk_d[0] = s_sl;
               for (int j = 1; j < D; j++) s_dk_d[j] = s_dk_q[j-1];
            end
         end

         // Carry and deskew flops, cleared asynchronously
         always_ff @(posedge CK or negedge RSTN) begin
            if (!RSTN) begin
               co_q <= 1'b0;
               for (int j = 0; j < D; j++) s_dk_q[j] <= '0;
            end else begin
               co_q   <= co_d;
               s_dk_q <= s_dk_d;
            end
         end
      end
   end
endmodule

// File: tb/tb_fadd_pipe_addsub.sv
// Bench for fadd_pipe_addsub: directed vectors on an 8-bit/2-bit instance,
// latency vectors on 7/3 and 4/8 instances, then a short randomized run of
// all three against a reference model through expected queues.
module tb_fadd_pipe_addsub;
   import fadd_pipe_pkg::*;

   logic CK;
   logic RSTN;
   int   n_vec;
   int   n_err;

   logic [31:0] exp_q8[$];
   logic [31:0] exp_q7[$];
   logic [31:0] exp_q4[$];

   fadd_pipe_addsub_if #(.WIDTH(8)) if8 ();
   fadd_pipe_addsub_if #(.WIDTH(7)) if7 ();
   fadd_pipe_addsub_if #(.WIDTH(4)) if4 ();

   fadd_pipe_addsub #(.WIDTH(8), .STAGE_BITS(2)) dut8 (.CK(CK), .RSTN(RSTN), .bus(if8));
   fadd_pipe_addsub #(.WIDTH(7), .STAGE_BITS(3)) dut7 (.CK(CK), .RSTN(RSTN), .bus(if7));
   fadd_pipe_addsub #(.WIDTH(4), .STAGE_BITS(8)) dut4 (.CK(CK), .RSTN(RSTN), .bus(if4));

   // ---------------- clock / reset ----------------
   initial CK = 1'b0;
   always #5 CK = ~CK;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   // ---------------- helpers ----------------
   function automatic logic [31:0] pk(input logic v, input logic c, input logic o,
                                      input logic [15:0] s);
      return {13'b0, v, c, o, s};
   endfunction

   function automatic logic [31:0] obs8();
      return pk(if8.VLD_O, if8.COUT, if8.OVF, 16'(if8.S));
   endfunction
   function automatic logic [31:0] obs7();
      return pk(if7.VLD_O, if7.COUT, if7.OVF, 16'(if7.S));
   endfunction
   function automatic logic [31:0] obs4();
      return pk(if4.VLD_O, if4.COUT, if4.OVF, 16'(if4.S));
   endfunction

   // Reference: sign-bit rule for overflow, plain wide addition for sum/carry
   function automatic logic [31:0] ref_op(input int w, input logic add, input logic ci,
                                          input logic [15:0] a, input logic [15:0] b);
      logic [16:0] m, ax, bx, sm;
      logic        co, ov;
      m  = (17'd1 << w) - 17'd1;
      ax = {1'b0, a} & m;
      bx = (add ? {1'b0, b} : ~{1'b0, b}) & m;
      sm = ax + bx + 17'(ci);
      co = sm[w];
      ov = (ax[w-1] == bx[w-1]) && (sm[w-1] != ax[w-1]);
      return pk(1'b1, co, ov, sm[15:0] & m[15:0]);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge CK);
      #1;
   endtask

   task automatic drv8(input logic vld, input logic add, input logic ci,
                       input logic [7:0] a, input logic [7:0] b);
      if8.VLD_I  = vld;
      if8.ADDSUB = add;
      if8.CI     = ci;
      if8.A      = a;
      if8.B      = b;
   endtask

   task automatic idle_all();
      drv8(1'b0, ADD, 1'b0, 8'h00, 8'h00);
      if7.VLD_I = 1'b0; if7.ADDSUB = ADD; if7.CI = 1'b0; if7.A = '0; if7.B = '0;
      if4.VLD_I = 1'b0; if4.ADDSUB = ADD; if4.CI = 1'b0; if4.A = '0; if4.B = '0;
      if8.CE = 1'b1; if7.CE = 1'b1; if4.CE = 1'b1;
   endtask

   // One randomized cycle on all three instances with queue scoreboarding
   task automatic rnd_cycle(input logic drain);
      if8.CE = drain ? 1'b1 : ($urandom_range(0, 7) != 0);
      if8.VLD_I = drain ? 1'b0 : ($urandom_range(0, 3) != 0);
      if8.ADDSUB = 1'($urandom_range(0, 1)); if8.CI = 1'($urandom_range(0, 1));
      if8.A = 8'($urandom_range(0, 255)); if8.B = 8'($urandom_range(0, 255));
      if (if8.CE && if8.VLD_O) begin
         if (exp_q8.size() == 0) check("rnd8_extra", obs8(), 32'h0);
         else check("rnd8", obs8(), exp_q8.pop_front());
      end
      if (if8.CE && if8.VLD_I)
         exp_q8.push_back(ref_op(8, if8.ADDSUB, if8.CI, 16'(if8.A), 16'(if8.B)));

      if7.CE = drain ? 1'b1 : ($urandom_range(0, 7) != 0);
      if7.VLD_I = drain ? 1'b0 : ($urandom_range(0, 3) != 0);
      if7.ADDSUB = 1'($urandom_range(0, 1)); if7.CI = 1'($urandom_range(0, 1));
      if7.A = 7'($urandom_range(0, 127)); if7.B = 7'($urandom_range(0, 127));
      if (if7.CE && if7.VLD_O) begin
         if (exp_q7.size() == 0) check("rnd7_extra", obs7(), 32'h0);
         else check("rnd7", obs7(), exp_q7.pop_front());
      end
      if (if7.CE && if7.VLD_I)
         exp_q7.push_back(ref_op(7, if7.ADDSUB, if7.CI, 16'(if7.A), 16'(if7.B)));

      if4.CE = drain ? 1'b1 : ($urandom_range(0, 7) != 0);
      if4.VLD_I = drain ? 1'b0 : ($urandom_range(0, 3) != 0);
      if4.ADDSUB = 1'($urandom_range(0, 1)); if4.CI = 1'($urandom_range(0, 1));
      if4.A = 4'($urandom_range(0, 15)); if4.B = 4'($urandom_range(0, 15));
      if (if4.CE && if4.VLD_O) begin
         if (exp_q4.size() == 0) check("rnd4_extra", obs4(), 32'h0);
         else check("rnd4", obs4(), exp_q4.pop_front());
      end
      if (if4.CE && if4.VLD_I)
         exp_q4.push_back(ref_op(4, if4.ADDSUB, if4.CI, 16'(if4.A), 16'(if4.B)));
   endtask

   // ---------------- directed and random stimulus ----------------
   initial begin
      n_vec = 0;
      n_err = 0;
      RSTN  = 1'b0;
      idle_all();
      #3;
      check("reset_state", obs8(), 32'h0);
      #10;
      RSTN = 1'b1;
      step();

      // Add with wrap: FF + 01
      drv8(1'b1, ADD, 1'b0, 8'hFF, 8'h01); step();
      drv8(1'b0, ADD, 1'b0, 8'h00, 8'h00); step(); step();
      check("add_lat_early", 32'(if8.VLD_O), 32'h0);
      step();
      check("add_wrap", obs8(), pk(1'b1, 1'b1, 1'b0, 16'h00));
      step();
      check("add_single", 32'(if8.VLD_O), 32'h0);

      // Subtract: 80-01 signed overflow, 00-01 borrow
      drv8(1'b1, SUB, 1'b1, 8'h80, 8'h01); step();
      drv8(1'b1, SUB, 1'b1, 8'h00, 8'h01); step();
      drv8(1'b0, ADD, 1'b0, 8'h00, 8'h00); step(); step();
      check("sub_ovf", obs8(), pk(1'b1, 1'b1, 1'b1, 16'h7F));
      step();
      check("sub_borrow", obs8(), pk(1'b1, 1'b0, 1'b0, 16'hFF));
      step();

      // Back-to-back with alternating mode
      drv8(1'b1, ADD, 1'b0, 8'd5,   8'd3);  step();
      drv8(1'b1, SUB, 1'b1, 8'd5,   8'd3);  step();
      drv8(1'b1, ADD, 1'b0, 8'd100, 8'd27); step();
      drv8(1'b1, SUB, 1'b1, 8'd100, 8'd27); step();
      drv8(1'b0, ADD, 1'b0, 8'h00, 8'h00);
      check("b2b_0", obs8(), pk(1'b1, 1'b0, 1'b0, 16'h08)); step();
      check("b2b_1", obs8(), pk(1'b1, 1'b1, 1'b0, 16'h02)); step();
      check("b2b_2", obs8(), pk(1'b1, 1'b0, 1'b0, 16'h7F)); step();
      check("b2b_3", obs8(), pk(1'b1, 1'b1, 1'b0, 16'h49)); step();
      check("b2b_end", 32'(if8.VLD_O), 32'h0);

      // CE stall: before results, then while a result is showing
      drv8(1'b1, ADD, 1'b0, 8'd1,  8'd1);  step();
      drv8(1'b1, ADD, 1'b0, 8'd10, 8'd20); step();
      drv8(1'b0, ADD, 1'b0, 8'h00, 8'h00);
      if8.CE = 1'b0; step();
      check("stall_idle", 32'(if8.VLD_O), 32'h0);
      step(); step();
      if8.CE = 1'b1; step(); step();
      check("stall_res0", obs8(), pk(1'b1, 1'b0, 1'b0, 16'h02));
      if8.CE = 1'b0; step();
      check("stall_hold0", obs8(), pk(1'b1, 1'b0, 1'b0, 16'h02));
      step();
      check("stall_hold1", obs8(), pk(1'b1, 1'b0, 1'b0, 16'h02));
      if8.CE = 1'b1; step();
      check("stall_res1", obs8(), pk(1'b1, 1'b0, 1'b0, 16'h1E));
      step();
      check("stall_end", 32'(if8.VLD_O), 32'h0);

      // Asynchronous reset with three ops still in flight
      drv8(1'b1, ADD, 1'b0, 8'h11, 8'h22); step();
      drv8(1'b1, ADD, 1'b0, 8'h01, 8'h02); step();
      drv8(1'b1, ADD, 1'b0, 8'h03, 8'h04); step();
      drv8(1'b1, ADD, 1'b0, 8'h05, 8'h06); step();
      drv8(1'b0, ADD, 1'b0, 8'h00, 8'h00);
      check("pre_rst", obs8(), pk(1'b1, 1'b0, 1'b0, 16'h33));
      #2 RSTN = 1'b0;
      #1 check("rst_async", obs8(), 32'h0);
      #2 RSTN = 1'b1;
      step();
      drv8(1'b1, ADD, 1'b1, 8'h40, 8'h3F);
      check("no_stale0", 32'(if8.VLD_O), 32'h0); step();
      drv8(1'b0, ADD, 1'b0, 8'h00, 8'h00);
      check("no_stale1", 32'(if8.VLD_O), 32'h0); step();
      check("no_stale2", 32'(if8.VLD_O), 32'h0); step();
      check("no_stale3", 32'(if8.VLD_O), 32'h0); step();
      check("post_rst_op", obs8(), pk(1'b1, 1'b0, 1'b1, 16'h80));
      step();

      // Bubbles with unknown operand data
      drv8(1'b1, ADD, 1'b0, 8'd2, 8'd2); step();
      if8.VLD_I = 1'b0; if8.A = 'x; if8.B = 'x; step();
      drv8(1'b1, ADD, 1'b0, 8'd3, 8'd3); step();
      if8.VLD_I = 1'b0; if8.A = 'x; if8.B = 'x; step();
      drv8(1'b0, ADD, 1'b0, 8'h00, 8'h00);
      check("bubble_op0", obs8(), pk(1'b1, 1'b0, 1'b0, 16'h04)); step();
      check("bubble_gap0", 32'(if8.VLD_O), 32'h0); step();
      check("bubble_op1", obs8(), pk(1'b1, 1'b0, 1'b0, 16'h06)); step();
      check("bubble_gap1", 32'(if8.VLD_O), 32'h0);

      // Latency of the 7/3 (three slices) and 4/8 (single slice) instances
      if7.VLD_I = 1'b1; if7.ADDSUB = ADD; if7.CI = 1'b0; if7.A = 7'h7F; if7.B = 7'h01;
      if4.VLD_I = 1'b1; if4.ADDSUB = ADD; if4.CI = 1'b0; if4.A = 4'h7;  if4.B = 4'h1;
      step();
      if7.VLD_I = 1'b0; if4.VLD_I = 1'b0;
      check("w4_lat1", obs4(), pk(1'b1, 1'b0, 1'b1, 16'h8));
      check("w7_early1", 32'(if7.VLD_O), 32'h0);
      step();
      check("w4_single", 32'(if4.VLD_O), 32'h0);
      check("w7_early2", 32'(if7.VLD_O), 32'h0);
      step();
      check("w7_lat3", obs7(), pk(1'b1, 1'b1, 1'b0, 16'h00));
      step();

      // Randomized traffic against the reference model, then drain
      for (int n = 0; n < 600; n++) begin
         rnd_cycle(1'b0);
         step();
      end
      for (int n = 0; n < 6; n++) begin
         rnd_cycle(1'b1);
         step();
      end
      check("q8_empty", 32'(exp_q8.size()), 32'h0);
      check("q7_empty", 32'(exp_q7.size()), 32'h0);
      check("q4_empty", 32'(exp_q4.size()), 32'h0);

      // ---------------- report ----------------
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
